// File: rtl/q2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : q2_pkg
//  Purpose  : Shared widths and FSM state encoding for the Q2 memory-bus
//             arbiter and its round-robin picker.
//  Contents : WORD_W, ADDR_W     - data and address bus widths
//             q2_state_e         - arbiter FSM states (IDLE/SETUP/STROBE/HOLD)
//  Revision : 1.0  initial release
// ============================================================================
package q2_pkg;

    localparam int WORD_W = 12;
    localparam int ADDR_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } q2_state_e;

endpackage : q2_pkg
`default_nettype wire

// File: rtl/q2_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : q2_rr_arb2
//  Purpose  : Two-input round-robin picker. When both inputs request, the one
//             not granted last wins. The last-grant flop advances on update.
//  Ports    : clk     in   system clock
//             rst     in   asynchronous active-high reset
//             req     in   [1:0] request vector (0 = CPU, 1 = panel)
//             update  in   record the current grant as the last grant
//             grant   out  [1:0] one-hot grant (combinational from req)
//  Revision : 1.0  initial release
// ============================================================================
module q2_rr_arb2 #(
    parameter bit CPU_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);
    import q2_pkg::*;

    // 1 = requester 1 (panel) was granted last. Resetting it to "panel" makes
    // the CPU win the first contention when CPU_FIRST is set.
    logic r_last_pnl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_pnl <= CPU_FIRST;
        end else if (update) begin
            r_last_pnl <= grant[1];
        end
    end

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_last_pnl ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule : q2_rr_arb2
`default_nettype wire

// File: rtl/q2_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : q2_mem_arbiter
//  Purpose  : Shares the Q2 12-bit memory bus between the CPU core and the
//             front-panel console. Each access runs SETUP, STROBE (STROBE_CYCLES
//             cycles) and HOLD so the RAM sees stable address/data around the
//             wrm/rdm edges. All outputs come straight from flops.
//  Ports    : clk, rst                    clock, async active-high reset
//             cpu_req/we/addr/wdata       CPU request (level, held to ack)
//             cpu_ack, cpu_rdata          CPU completion pulse, read data
//             pnl_req/we/addr/wdata       panel deposit/examine request
//             pnl_ack, pnl_rdata          panel completion pulse, read data
//             abus, dbus, rdm, wrm        memory bus (dbus driven on writes)
//             busy                        FSM not in IDLE
//  Revision : 1.0  initial release
// ============================================================================
module q2_mem_arbiter
    import q2_pkg::*;
#(
    parameter int STROBE_CYCLES = 1,
    parameter bit CPU_FIRST     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [WORD_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [WORD_W-1:0] cpu_rdata,
    input  logic              pnl_req,
    input  logic              pnl_we,
    input  logic [ADDR_W-1:0] pnl_addr,
    input  logic [WORD_W-1:0] pnl_wdata,
    output logic              pnl_ack,
    output logic [WORD_W-1:0] pnl_rdata,
    output logic [ADDR_W-1:0] abus,
    inout  wire  [WORD_W-1:0] dbus,
    output logic              rdm,
    output logic              wrm,
    output logic              busy
);

    localparam int CNT_W = $clog2(STROBE_CYCLES + 1);

    q2_state_e         r_state,     w_state_nx;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_nx;
    logic              r_own_pnl,   w_own_pnl_nx;
    logic              r_we,        w_we_nx;
    logic [ADDR_W-1:0] r_abus,      w_abus_nx;
    logic [WORD_W-1:0] r_wdata,     w_wdata_nx;
    logic              r_dbus_oe,   w_dbus_oe_nx;
    logic              r_rdm,       w_rdm_nx;
    logic              r_wrm,       w_wrm_nx;
    logic              r_cpu_ack,   w_cpu_ack_nx;
    logic              r_pnl_ack,   w_pnl_ack_nx;
    logic [WORD_W-1:0] r_cpu_rdata, w_cpu_rdata_nx;
    logic [WORD_W-1:0] r_pnl_rdata, w_pnl_rdata_nx;
    logic              r_busy,      w_busy_nx;

    logic [1:0]        w_req;
    logic [1:0]        w_grant;
    logic              w_arb_update;

    // Requests are only looked at in IDLE, so the pointer only moves on a grant.
    assign w_req        = {pnl_req, cpu_req};
    assign w_arb_update = (r_state == ST_IDLE) && (|w_req);

    q2_rr_arb2 #(
        .CPU_FIRST (CPU_FIRST)
    ) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (w_req),
        .update (w_arb_update),
        .grant  (w_grant)
    );

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_own_pnl   <= 1'b0;
            r_we        <= 1'b0;
            r_abus      <= '0;
            r_wdata     <= '0;
            r_dbus_oe   <= 1'b0;
            r_rdm       <= 1'b0;
            r_wrm       <= 1'b0;
            r_cpu_ack   <= 1'b0;
            r_pnl_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_pnl_rdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_own_pnl   <= w_own_pnl_nx;
            r_we        <= w_we_nx;
            r_abus      <= w_abus_nx;
            r_wdata     <= w_wdata_nx;
            r_dbus_oe   <= w_dbus_oe_nx;
            r_rdm       <= w_rdm_nx;
            r_wrm       <= w_wrm_nx;
            r_cpu_ack   <= w_cpu_ack_nx;
            r_pnl_ack   <= w_pnl_ack_nx;
            r_cpu_rdata <= w_cpu_rdata_nx;
            r_pnl_rdata <= w_pnl_rdata_nx;
            r_busy      <= w_busy_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and next-output logic. Strobes and acks are computed one
    // cycle ahead so they come out of flops aligned with the state.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        w_own_pnl_nx   = r_own_pnl;
        w_we_nx        = r_we;
        w_abus_nx      = r_abus;
        w_wdata_nx     = r_wdata;
        w_dbus_oe_nx   = r_dbus_oe;
        w_rdm_nx       = 1'b0;
        w_wrm_nx       = 1'b0;
        w_cpu_ack_nx   = 1'b0;
        w_pnl_ack_nx   = 1'b0;
        w_cpu_rdata_nx = r_cpu_rdata;
        w_pnl_rdata_nx = r_pnl_rdata;
        w_busy_nx      = r_busy;

        case (r_state)
            ST_IDLE: begin
                w_dbus_oe_nx = 1'b0;
                if (w_grant[0]) begin
                    w_own_pnl_nx = 1'b0;
                    w_we_nx      = cpu_we;
                    w_abus_nx    = cpu_addr;
                    w_wdata_nx   = cpu_wdata;
                    w_dbus_oe_nx = cpu_we;
                end else if (w_grant[1]) begin
                    w_own_pnl_nx = 1'b1;
                    w_we_nx      = pnl_we;
                    w_abus_nx    = pnl_addr;
                    w_wdata_nx   = pnl_wdata;
                    w_dbus_oe_nx = pnl_we;
                end
                if (|w_grant) begin
                    w_state_nx = ST_SETUP;
                    w_busy_nx  = 1'b1;
                end
            end

            ST_SETUP: begin
                w_state_nx = ST_STROBE;
                w_cnt_nx   = CNT_W'(STROBE_CYCLES);
                w_rdm_nx   = ~r_we;
                w_wrm_nx   = r_we;
            end

            ST_STROBE: begin
                if (r_cnt == CNT_W'(1)) begin
                    // Last strobe edge: RAM is still driving dbus for a read.
                    w_state_nx = ST_HOLD;
                    if (!r_we) begin
                        if (r_own_pnl) begin
                            w_pnl_rdata_nx = dbus;
                        end else begin
                            w_cpu_rdata_nx = dbus;
                        end
                    end
                    w_cpu_ack_nx = ~r_own_pnl;
                    w_pnl_ack_nx = r_own_pnl;
                end else begin
                    w_cnt_nx = r_cnt - CNT_W'(1);
                    w_rdm_nx = ~r_we;
                    w_wrm_nx = r_we;
                end
            end

            ST_HOLD: begin
                w_state_nx   = ST_IDLE;
                w_dbus_oe_nx = 1'b0;
                w_busy_nx    = 1'b0;
            end

            default: begin
                w_state_nx   = ST_IDLE;
                w_dbus_oe_nx = 1'b0;
                w_busy_nx    = 1'b0;
            end
        endcase
    end

    assign dbus      = r_dbus_oe ? r_wdata : {WORD_W{1'bz}};
    assign abus      = r_abus;
    assign rdm       = r_rdm;
    assign wrm       = r_wrm;
    assign cpu_ack   = r_cpu_ack;
    assign pnl_ack   = r_pnl_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign pnl_rdata = r_pnl_rdata;
    assign busy      = r_busy;

endmodule : q2_mem_arbiter
`default_nettype wire

// File: tb/tb_q2_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_q2_mem_arbiter
//  Purpose  : Self-checking bench for q2_mem_arbiter. One instance with
//             STROBE_CYCLES=1 and one with STROBE_CYCLES=3, each on its own
//             behavioural RAM. Expected acks are queued when a request is
//             driven and popped by a monitor when an ack appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_q2_mem_arbiter;

    localparam int S1 = 1;
    localparam int S3 = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance with one strobe cycle ----------------
    logic        cpu_req = 0, cpu_we = 0, pnl_req = 0, pnl_we = 0;
    logic [11:0] cpu_addr = 0, cpu_wdata = 0, pnl_addr = 0, pnl_wdata = 0;
    logic        cpu_ack, pnl_ack, rdm, wrm, busy;
    logic [11:0] cpu_rdata, pnl_rdata, abus;
    wire  [11:0] dbus;
    logic [11:0] ram [0:4095];

    assign dbus = rdm ? ram[abus] : 12'bz;
    always @(posedge wrm) ram[abus] <= dbus;

    q2_mem_arbiter #(.STROBE_CYCLES(S1), .CPU_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .pnl_req(pnl_req), .pnl_we(pnl_we), .pnl_addr(pnl_addr), .pnl_wdata(pnl_wdata),
        .pnl_ack(pnl_ack), .pnl_rdata(pnl_rdata),
        .abus(abus), .dbus(dbus), .rdm(rdm), .wrm(wrm), .busy(busy)
    );

    // ---------------- instance with three strobe cycles ----------------
    logic        cpu_req3 = 0, cpu_we3 = 0, pnl_req3 = 0, pnl_we3 = 0;
    logic [11:0] cpu_addr3 = 0, cpu_wdata3 = 0, pnl_addr3 = 0, pnl_wdata3 = 0;
    logic        cpu_ack3, pnl_ack3, rdm3, wrm3, busy3;
    logic [11:0] cpu_rdata3, pnl_rdata3, abus3;
    wire  [11:0] dbus3;
    logic [11:0] ram3 [0:4095];

    assign dbus3 = rdm3 ? ram3[abus3] : 12'bz;
    always @(posedge wrm3) ram3[abus3] <= dbus3;

    q2_mem_arbiter #(.STROBE_CYCLES(S3), .CPU_FIRST(1'b1)) dut3 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
        .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
        .pnl_req(pnl_req3), .pnl_we(pnl_we3), .pnl_addr(pnl_addr3), .pnl_wdata(pnl_wdata3),
        .pnl_ack(pnl_ack3), .pnl_rdata(pnl_rdata3),
        .abus(abus3), .dbus(dbus3), .rdm(rdm3), .wrm(wrm3), .busy(busy3)
    );

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          pnl;
        bit          we;
        logic [11:0] rdata;
    } exp_t;

    exp_t sb[$];
    bit   mon_en = 1'b0;

    // Scoreboard monitor for the STROBE_CYCLES=1 instance.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            exp_t e;
            check("strobe_exclusive", {31'd0, rdm & wrm}, 32'd0);
            if (cpu_ack || pnl_ack) begin
                check("single_ack", {31'd0, cpu_ack & pnl_ack}, 32'd0);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_ack: cpu_ack=%0b pnl_ack=%0b, expected none (t=%0t)",
                             cpu_ack, pnl_ack, $time);
                end else begin
                    e = sb.pop_front();
                    check("ack_owner", {31'd0, pnl_ack}, {31'd0, e.pnl});
                    if (!e.we) begin
                        check("rdata", {20'd0, pnl_ack ? pnl_rdata : cpu_rdata}, {20'd0, e.rdata});
                    end
                end
            end
        end
    end

    // One single-requester access on the S=1 instance; checks latency and
    // strobe widths here, data and ownership in the monitor.
    task automatic access(input bit pnl, input bit we, input logic [11:0] a,
                          input logic [11:0] d, input logic [11:0] exp_rd);
        int cyc, nw, nr;
        bit got;
        exp_t e;
        @(negedge clk);
        if (pnl) begin
            pnl_req = 1; pnl_we = we; pnl_addr = a; pnl_wdata = d;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
        e.pnl = pnl; e.we = we; e.rdata = exp_rd;
        sb.push_back(e);
        cyc = 0; nw = 0; nr = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (wrm) nw++;
            if (rdm) nr++;
            if (pnl ? pnl_ack : cpu_ack) got = 1;
        end
        cpu_req = 0;
        pnl_req = 0;
        check("ack_seen", {31'd0, got}, 32'd1);
        check("latency", cyc, 2 + S1);
        check("wrm_cycles", nw, we ? S1 : 0);
        check("rdm_cycles", nr, we ? 0 : S1);
        if (we) check("ram_written", {20'd0, ram[a]}, {20'd0, d});
    endtask

    typedef struct {
        bit          pnl;
        bit          we;
        logic [11:0] addr;
        logic [11:0] wdata;
        logic [11:0] exp_rd;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int   cyc, nacks, last, cpu_n, pnl_n, nw, bad, acks_in_rst;
        bit   got;
        exp_t e;

        for (int i = 0; i < 4096; i++) begin
            ram[i]  = 12'h000;
            ram3[i] = 12'h000;
        end

        vecs[0] = '{0, 1, 12'h7FF, 12'h123, 12'h000};
        vecs[1] = '{1, 0, 12'h7FF, 12'h000, 12'h123};
        vecs[2] = '{1, 1, 12'h000, 12'hFFF, 12'h000};
        vecs[3] = '{0, 0, 12'h000, 12'h000, 12'hFFF};
        vecs[4] = '{0, 1, 12'hFFF, 12'h800, 12'h000};
        vecs[5] = '{1, 0, 12'hFFF, 12'h000, 12'h800};
        vecs[6] = '{0, 0, 12'h010, 12'h000, 12'hA01};
        vecs[7] = '{1, 1, 12'h7FF, 12'h0AA, 12'h000};
        vecs[8] = '{0, 0, 12'h7FF, 12'h000, 12'h0AA};

        // ---- reset with both requests high ----
        #1 rst = 1;
        cpu_req = 1; pnl_req = 1;
        repeat (3) @(negedge clk);
        check("rst_abus", {20'd0, abus}, 32'd0);
        check("rst_rdm", {31'd0, rdm}, 32'd0);
        check("rst_wrm", {31'd0, wrm}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_acks", {30'd0, cpu_ack, pnl_ack}, 32'd0);
        check("rst_rdata", {8'd0, cpu_rdata, pnl_rdata}, 32'd0);
        cpu_req = 0; pnl_req = 0;
        @(negedge clk);
        rst = 0;
        mon_en = 1;

        // ---- contention: both held high, CPU favoured first ----
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h010; cpu_wdata = 12'hA01;
        pnl_req = 1; pnl_we = 1; pnl_addr = 12'h020; pnl_wdata = 12'hB02;
        e = '{0, 1, 12'h000}; sb.push_back(e);
        e = '{1, 1, 12'h000}; sb.push_back(e);
        e = '{0, 0, 12'hB02}; sb.push_back(e);
        e = '{1, 0, 12'hA01}; sb.push_back(e);
        nacks = 0; cyc = 0; last = 0; cpu_n = 0; pnl_n = 0;
        while (nacks < 4 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (cpu_ack || pnl_ack) begin
                nacks++;
                if (nacks == 1) check("contention_first_latency", cyc, 3);
                else            check("contention_ack_spacing", cyc - last, 4);
                last = cyc;
                if (cpu_ack) begin
                    cpu_n++;
                    if (cpu_n == 1) begin cpu_we = 0; cpu_addr = 12'h020; end
                    else cpu_req = 0;
                end
                if (pnl_ack) begin
                    pnl_n++;
                    if (pnl_n == 1) begin pnl_we = 0; pnl_addr = 12'h010; end
                    else pnl_req = 0;
                end
            end
        end
        cpu_req = 0; pnl_req = 0;
        check("contention_acks", nacks, 4);

        // ---- table of single-requester accesses ----
        for (int i = 0; i < 9; i++) begin
            access(vecs[i].pnl, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
        end

        // ---- three-cycle strobe write ----
        @(negedge clk);
        cpu_req3 = 1; cpu_we3 = 1; cpu_addr3 = 12'h3C3; cpu_wdata3 = 12'h5A5;
        cyc = 0; nw = 0; bad = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (wrm3) nw++;
            if (busy3 && (abus3 !== 12'h3C3 || dbus3 !== 12'h5A5)) bad++;
            if (cpu_ack3) got = 1;
        end
        cpu_req3 = 0;
        check("s3_ack_seen", {31'd0, got}, 32'd1);
        check("s3_latency", cyc, 2 + S3);
        check("s3_wrm_cycles", nw, S3);
        check("s3_bus_stable", bad, 0);
        check("s3_ram", {20'd0, ram3[12'h3C3]}, 32'h5A5);

        // ---- reset during the strobe of a write ----
        @(negedge clk);
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h100; cpu_wdata = 12'h777;
        @(negedge clk);
        check("abort_setup_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("abort_wrm_before", {31'd0, wrm}, 32'd1);
        rst = 1;
        cpu_req = 0;
        #1;
        check("abort_wrm_drop", {31'd0, wrm}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_abus", {20'd0, abus}, 32'd0);
        acks_in_rst = 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack || pnl_ack) acks_in_rst++;
        end
        check("abort_no_ack", acks_in_rst, 0);
        rst = 0;
        sb.delete();
        access(0, 0, 12'h7FF, 12'h000, 12'h0AA);
        repeat (4) @(negedge clk);
        check("abort_no_retry", {31'd0, busy}, 32'd0);
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_q2_mem_arbiter
`default_nettype wire
